// File: rtl/udp_pkg.sv
// Shared constants, state encoding and header field helper for the UDP receive filter.
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;

    // Byte offsets of the big-endian header fields
    localparam int OFF_SRC  = 0;
    localparam int OFF_DST  = 2;
    localparam int OFF_LEN  = 4;
    localparam int OFF_CSUM = 6;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Header bytes 0..5 sit in a 48-bit shift register, byte 0 in the top octet.
    function automatic logic [15:0] hdr_field(input logic [47:0] sh, input int off);
        return sh[(OFF_CSUM - 2 - off) * 8 +: 16];
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority match of a destination port against the local port table.
module udp_port_match #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [15:0]           dst,
    input  logic [16*N_PORTS-1:0] port_table,
    input  logic [N_PORTS-1:0]    port_en,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the top so the lowest matching enabled entry is the one left standing
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (port_en[i] && (port_table[16*i +: 16] == dst)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/udp_rx_filter.sv
// UDP receive filter: parses the 8-byte header, filters on destination port and
// forwards the payload through a single registered output stage.
module udp_rx_filter
    import udp_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic [16*N_PORTS-1:0] port_table,
    input  logic [N_PORTS-1:0]    port_en,
    input  logic                  promisc,
    output logic                  hdr_valid,
    output logic [15:0]           src_port,
    output logic [15:0]           dst_port,
    output logic [15:0]           udp_len,
    output logic [IDX_W-1:0]      port_idx,
    output logic                  err_short,
    output logic                  err_len,
    output logic                  drop_port,
    output logic [CNT_W-1:0]      cnt_ok,
    output logic [CNT_W-1:0]      cnt_drop
);

    localparam logic [2:0]  LAST_BYTE = 3'(UDP_HDR_BYTES - 1);
    localparam logic [15:0] HDR_LEN   = 16'(UDP_HDR_BYTES);

    state_e             state_q, state_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [47:0]        hdr_sh_q, hdr_sh_d;
    logic [15:0]        rem_q, rem_d;
    logic [7:0]         m_tdata_q, m_tdata_d;
    logic               m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [15:0]        src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [IDX_W-1:0]   port_idx_q, port_idx_d;
    logic               err_short_q, err_short_d, err_len_q, err_len_d;
    logic               drop_port_q, drop_port_d;
    logic [CNT_W-1:0]   cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;

    logic               s_ready_s, beat_s, ok_inc_s, drop_inc_s, hit_s;
    logic [IDX_W-1:0]   idx_s;
    logic [15:0]        dst_s, len_s;

    assign dst_s = hdr_field(hdr_sh_q, OFF_DST);
    assign len_s = hdr_field(hdr_sh_q, OFF_LEN);

    udp_port_match #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_match (
        .dst        (dst_s),
        .port_table (port_table),
        .port_en    (port_en),
        .hit        (hit_s),
        .idx        (idx_s)
    );

    // Next-state, output-stage and counter logic
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hdr_sh_d    = hdr_sh_q;
        rem_d       = rem_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        port_idx_d  = port_idx_q;
        hdr_valid_d = 1'b0;
        err_short_d = 1'b0;
        err_len_d   = 1'b0;
        drop_port_d = 1'b0;
        ok_inc_s    = 1'b0;
        drop_inc_s  = 1'b0;

        s_ready_s = (state_q == ST_PAYLOAD) ? (!m_tvalid_q || m_tready) : 1'b1;
        beat_s    = s_tvalid && s_ready_s;

        // A held beat retires on its own handshake whatever the parser is doing
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end

        case (state_q)
            ST_HDR: begin
                if (beat_s) begin
                    if (byte_cnt_q < 3'(OFF_CSUM)) begin
                        hdr_sh_d = {hdr_sh_q[39:0], s_tdata};
                    end else begin
                        hdr_sh_d = hdr_sh_q;
                    end
                    if (byte_cnt_q != LAST_BYTE) begin
                        if (s_tlast) begin
                            err_short_d = 1'b1;
                            drop_inc_s  = 1'b1;
                            byte_cnt_d  = 3'd0;
                        end else begin
                            byte_cnt_d  = byte_cnt_q + 3'd1;
                        end
                    end else begin
                        byte_cnt_d = 3'd0;
                        if (len_s < HDR_LEN) begin
                            err_len_d  = 1'b1;
                            drop_inc_s = 1'b1;
                            state_d    = s_tlast ? ST_HDR : ST_DRAIN;
                        end else if (!hit_s && !promisc) begin
                            drop_port_d = 1'b1;
                            drop_inc_s  = 1'b1;
                            state_d     = s_tlast ? ST_HDR : ST_DRAIN;
                        end else if (s_tlast && (len_s != HDR_LEN)) begin
                            // Datagram ended with the header yet promised a payload
                            err_short_d = 1'b1;
                            drop_inc_s  = 1'b1;
                            state_d     = ST_HDR;
                        end else begin
                            hdr_valid_d = 1'b1;
                            src_d       = hdr_field(hdr_sh_q, OFF_SRC);
                            dst_d       = dst_s;
                            len_d       = len_s;
                            port_idx_d  = hit_s ? idx_s : '0;
                            if (len_s == HDR_LEN) begin
                                ok_inc_s = 1'b1;
                                state_d  = s_tlast ? ST_HDR : ST_DRAIN;
                            end else begin
                                state_d  = ST_PAYLOAD;
                                rem_d    = len_s - HDR_LEN;
                            end
                        end
                    end
                end else begin
                    hdr_sh_d = hdr_sh_q;
                end
            end
            ST_PAYLOAD: begin
                if (beat_s) begin
                    m_tdata_d  = s_tdata;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (rem_q == 16'd1) || s_tlast;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        ok_inc_s = 1'b1;
                        state_d  = s_tlast ? ST_HDR : ST_DRAIN;
                    end else if (s_tlast) begin
                        err_short_d = 1'b1;
                        drop_inc_s  = 1'b1;
                        state_d     = ST_HDR;
                    end else begin
                        state_d     = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_DRAIN: begin
                if (beat_s && s_tlast) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_HDR;
                byte_cnt_d = 3'd0;
            end
        endcase

        if (ok_inc_s && (cnt_ok_q != {CNT_W{1'b1}})) begin
            cnt_ok_d = cnt_ok_q + CNT_W'(1);
        end else begin
            cnt_ok_d = cnt_ok_q;
        end
        if (drop_inc_s && (cnt_drop_q != {CNT_W{1'b1}})) begin
            cnt_drop_d = cnt_drop_q + CNT_W'(1);
        end else begin
            cnt_drop_d = cnt_drop_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR;
            byte_cnt_q  <= 3'd0;
            hdr_sh_q    <= 48'd0;
            rem_q       <= 16'd0;
            m_tdata_q   <= 8'd0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            src_q       <= 16'd0;
            dst_q       <= 16'd0;
            len_q       <= 16'd0;
            port_idx_q  <= '0;
            err_short_q <= 1'b0;
            err_len_q   <= 1'b0;
            drop_port_q <= 1'b0;
            cnt_ok_q    <= '0;
            cnt_drop_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            hdr_sh_q    <= hdr_sh_d;
            rem_q       <= rem_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            hdr_valid_q <= hdr_valid_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            port_idx_q  <= port_idx_d;
            err_short_q <= err_short_d;
            err_len_q   <= err_len_d;
            drop_port_q <= drop_port_d;
            cnt_ok_q    <= cnt_ok_d;
            cnt_drop_q  <= cnt_drop_d;
        end
    end

    assign s_tready  = s_ready_s;
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign hdr_valid = hdr_valid_q;
    assign src_port  = src_q;
    assign dst_port  = dst_q;
    assign udp_len   = len_q;
    assign port_idx  = port_idx_q;
    assign err_short = err_short_q;
    assign err_len   = err_len_q;
    assign drop_port = drop_port_q;
    assign cnt_ok    = cnt_ok_q;
    assign cnt_drop  = cnt_drop_q;

endmodule

// File: tb/tb_udp_rx_filter.sv
// Bench for udp_rx_filter: directed datagram table, hand sequences and random
// datagrams, all checked against a datagram-level reference model.
module tb_udp_rx_filter;

    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       s_tdata = 8'd0;
    logic             s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [7:0]       m_tdata;
    logic             m_tvalid, m_tlast, m_tready;
    logic [16*NP-1:0] port_table;
    logic [NP-1:0]    port_en = 4'b1101;
    logic             promisc = 1'b0;
    logic             hdr_valid, err_short, err_len, drop_port;
    logic [15:0]      src_port, dst_port, udp_len;
    logic [1:0]       port_idx;
    logic [CW-1:0]    cnt_ok, cnt_drop;

    logic [15:0] tbl [NP] = '{16'h0035, 16'h0050, 16'h0050, 16'h0035};
    assign port_table = {tbl[3], tbl[2], tbl[1], tbl[0]};

    always #5 clk = ~clk;

    udp_rx_filter #(.N_PORTS(NP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .port_table(port_table), .port_en(port_en), .promisc(promisc),
        .hdr_valid(hdr_valid), .src_port(src_port), .dst_port(dst_port), .udp_len(udp_len),
        .port_idx(port_idx), .err_short(err_short), .err_len(err_len), .drop_port(drop_port),
        .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
    );

    typedef enum int {K_OK = 0, K_SHORT = 1, K_LEN = 2, K_PORT = 3} kind_e;
    typedef struct {
        logic [15:0] dst;
        logic [15:0] len;
        int          nbytes;
        logic        prom;
        logic [7:0]  base;
        int          exp_nout;
        kind_e       exp_kind;
    } vec_t;
    typedef struct {logic [7:0] d; logic l;} beat_t;

    int          vectors = 0, miscompares = 0;
    int          n_short = 0, n_len = 0, n_port = 0, n_hv = 0;
    int          rdy_mode = 1, pidx = 0;
    bit          gap_en = 1'b0;
    logic [3:0]  pat_v = 4'b1001;
    logic [7:0]  dg_q [$];
    beat_t       got_q [$], exp_q [$];

    // reference model state
    kind_e       m_kind;
    bit          m_acc;
    int          m_ok = 0, m_drop = 0;
    logic [15:0] m_src = 16'd0, m_dst = 16'd0, m_len = 16'd0;
    logic [1:0]  m_pidx = 2'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // m_tready driver: random, always ready, the 1-0-0-1 pattern, or stalled
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_tready = ($urandom_range(0, 3) != 0);
                1: m_tready = 1'b1;
                2: begin m_tready = (pidx < 4) ? pat_v[3 - pidx] : 1'b1; pidx++; end
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (m_tvalid && m_tready) got_q.push_back('{m_tdata, m_tlast});
            if (hdr_valid) n_hv++;
            if (err_short) n_short++;
            if (err_len)   n_len++;
            if (drop_port) n_port++;
            if (m_tvalid && !m_tready && !m_tlast) chk("hold_ready", {63'd0, s_tready}, 64'd0);
        end
    end

    task automatic build_dg(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                            input int n, input logic [7:0] base);
        dg_q.delete();
        dg_q = '{src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'hBE, 8'hEF};
        for (int j = 0; j < n - 8; j++) dg_q.push_back(base + 8'(17 * j));
        while (dg_q.size() > n) void'(dg_q.pop_back());
    endtask

    // Datagram-level model: outcome, expected payload beats, counters, held header fields
    task automatic model_dg(input logic prom);
        int n, hit, p, avail, nout;
        logic [15:0] dst, ln;
        n = dg_q.size();
        exp_q.delete();
        m_acc = 1'b0;
        if (n < 8) m_kind = K_SHORT;
        else begin
            dst = {dg_q[2], dg_q[3]};
            ln  = {dg_q[4], dg_q[5]};
            hit = -1;
            for (int i = NP - 1; i >= 0; i--) if (port_en[i] && tbl[i] == dst) hit = i;
            if (ln < 16'd8) m_kind = K_LEN;
            else if (hit < 0 && !prom) m_kind = K_PORT;
            else if (n == 8 && ln > 16'd8) m_kind = K_SHORT;
            else begin
                m_acc  = 1'b1;
                m_src  = {dg_q[0], dg_q[1]};
                m_dst  = dst;
                m_len  = ln;
                m_pidx = (hit < 0) ? 2'd0 : 2'(hit);
                p      = int'(ln) - 8;
                avail  = n - 8;
                nout   = (p < avail) ? p : avail;
                for (int j = 0; j < nout; j++) exp_q.push_back('{dg_q[8 + j], (j == nout - 1)});
                m_kind = (avail >= p) ? K_OK : K_SHORT;
            end
        end
        if (m_kind == K_OK) m_ok = (m_ok == CMAX) ? CMAX : m_ok + 1;
        else m_drop = (m_drop == CMAX) ? CMAX : m_drop + 1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_tready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("s_tready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic run_dg(input logic prom, input bit use_exp, input int exp_nout,
                          input kind_e exp_k, input bit bp);
        int s0, l0, p0, h0, w, nc;
        kind_e k;
        promisc = prom;
        model_dg(prom);
        k = use_exp ? exp_k : m_kind;
        s0 = n_short; l0 = n_len; p0 = n_port; h0 = n_hv;
        for (int i = 0; i < dg_q.size(); i++) begin
            if (bp && i == 8) begin pidx = 0; rdy_mode = 2; end
            send_byte(dg_q[i], i == dg_q.size() - 1);
        end
        w = 0;
        while (got_q.size() < exp_q.size() && w < 100) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        chk("nout", got_q.size(), exp_q.size());
        if (use_exp) chk("tbl_nout", got_q.size(), exp_nout);
        nc = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nc; i++)
            chk("beat", {got_q[i].d, got_q[i].l}, {exp_q[i].d, exp_q[i].l});
        chk("pulses", {8'(n_short - s0), 8'(n_len - l0), 8'(n_port - p0), 8'(n_hv - h0)},
            {8'(k == K_SHORT), 8'(k == K_LEN), 8'(k == K_PORT), 8'(m_acc)});
        chk("cnt_ok", cnt_ok, m_ok);
        chk("cnt_drop", cnt_drop, m_drop);
        chk("hdr_fields", {src_port, dst_port, udp_len, port_idx}, {m_src, m_dst, m_len, m_pidx});
        got_q.delete();
        @(posedge clk); #1;
    endtask

    vec_t vecs [12];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0050, 16'h000C, 12, 1'b0, 8'hAA, 4, K_OK};
        vecs[1]  = '{16'h0051, 16'h000C, 12, 1'b0, 8'hAA, 0, K_PORT};
        vecs[2]  = '{16'h0051, 16'h000C, 12, 1'b1, 8'hAA, 4, K_OK};
        vecs[3]  = '{16'h0050, 16'h000A, 16, 1'b0, 8'h11, 2, K_OK};
        vecs[4]  = '{16'h0050, 16'h0010, 11, 1'b0, 8'h31, 3, K_SHORT};
        vecs[5]  = '{16'h0050, 16'h0004, 12, 1'b0, 8'h05, 0, K_LEN};
        vecs[6]  = '{16'h0050, 16'h000C,  5, 1'b0, 8'h00, 0, K_SHORT};
        vecs[7]  = '{16'h0035, 16'h0008,  8, 1'b0, 8'h00, 0, K_OK};
        vecs[8]  = '{16'h0035, 16'h0008, 10, 1'b0, 8'h70, 0, K_OK};
        vecs[9]  = '{16'h0050, 16'h0020,  8, 1'b0, 8'h00, 0, K_SHORT};
        vecs[10] = '{16'h1F90, 16'h000C, 12, 1'b0, 8'h40, 0, K_PORT};
        vecs[11] = '{16'h0050, 16'h0009,  9, 1'b0, 8'h99, 1, K_OK};

        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {s_tready, m_tvalid, m_tlast, m_tdata, src_port, dst_port, udp_len,
                            port_idx, cnt_ok, cnt_drop}, {1'b1, 1'b0, 1'b0, 8'd0, 48'd0, 2'd0, 8'd0});
        @(posedge clk); #1;

        rdy_mode = 0;
        for (int v = 0; v < 12; v++) begin
            build_dg(16'h1234, vecs[v].dst, vecs[v].len, vecs[v].nbytes, vecs[v].base);
            run_dg(vecs[v].prom, 1'b1, vecs[v].exp_nout, vecs[v].exp_kind, 1'b0);
        end

        // Backpressure 1-0-0-1 during the payload
        rdy_mode = 1;
        build_dg(16'h1234, 16'h0050, 16'h000C, 12, 8'hAA);
        run_dg(1'b0, 1'b1, 4, K_OK, 1'b1);
        rdy_mode = 1;

        // Reset while a payload beat is held
        rdy_mode = 3;
        build_dg(16'hCAFE, 16'h0050, 16'h0020, 40, 8'h01);
        for (int i = 0; i < 9; i++) send_byte(dg_q[i], 1'b0);
        @(negedge clk);
        chk("held_before_reset", {63'd0, m_tvalid}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid", {m_tvalid, cnt_ok, cnt_drop, src_port, port_idx}, {1'b0, 8'd0, 16'd0, 2'd0});
        m_ok = 0; m_drop = 0; m_src = 16'd0; m_dst = 16'd0; m_len = 16'd0; m_pidx = 2'd0;
        got_q.delete();
        rdy_mode = 1;
        @(posedge clk); #1;
        build_dg(16'h1234, 16'h0050, 16'h000C, 12, 8'hAA);
        run_dg(1'b0, 1'b1, 4, K_OK, 1'b0);

        // Random datagrams; counters saturate at 15 along the way
        rdy_mode = 0;
        gap_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [15:0] dsts [4];
            logic [15:0] ln;
            int n, mode;
            dsts = '{16'h0035, 16'h0050, 16'h0051, 16'h1F90};
            ln = 16'($urandom_range(0, 24));
            mode = $urandom_range(0, 3);
            case (mode)
                0: n = $urandom_range(1, 7);
                1: n = (ln > 16'd8) ? int'(ln) : 8;
                2: n = ((ln > 16'd8) ? int'(ln) : 8) + $urandom_range(1, 4);
                default: n = $urandom_range(8, 30);
            endcase
            build_dg(16'($urandom), dsts[$urandom_range(0, 3)], ln, n, 8'($urandom));
            run_dg(1'($urandom_range(0, 1)), 1'b0, 0, K_OK, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
